// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch and control stages: FSM states, opcode
// length classes and the two-byte instruction decoder.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_OD    = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [7:0] OPC_NOP = 8'h00;

  // Exact two-byte opcodes
  localparam logic [7:0] OPC_2B_03 = 8'b0000_0011;
  localparam logic [7:0] OPC_2B_05 = 8'b0000_0101;

  // Two-byte classes matched on the upper five bits
  localparam logic [4:0] CLS_0000_1 = 5'b0000_1;
  localparam logic [4:0] CLS_0011_0 = 5'b0011_0;
  localparam logic [4:0] CLS_0101_1 = 5'b0101_1;
  localparam logic [4:0] CLS_1111_1 = 5'b1111_1;

  function automatic logic is_two_byte(input logic [7:0] opcode);
    logic [4:0] hi5;
    logic       hi_class;
    hi5      = opcode[7:3];
    // 1xxx_1_xxx is two-byte except the 1111_1_xxx group
    hi_class = opcode[7] && opcode[3] && (hi5 != CLS_1111_1);
    return (opcode == OPC_2B_03) || (opcode == OPC_2B_05) ||
           (hi5 == CLS_0000_1) || (hi5 == CLS_0011_0) ||
           (hi5 == CLS_0101_1) || hi_class;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program memory port on one side, control stage on the other.
interface fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_data;
  logic              stall;
  logic              l_pc;
  logic [ADDR_W-1:0] pc_target;
  logic [7:0]        opcode_out;
  logic [7:0]        operand_out;
  logic [ADDR_W-1:0] ret_addr_out;
  logic              valid_out;

  modport master (
    output imem_addr, opcode_out, operand_out, ret_addr_out, valid_out,
    input  imem_data, stall, l_pc, pc_target
  );

  modport slave (
    input  imem_addr, opcode_out, operand_out, ret_addr_out, valid_out,
    output imem_data, stall, l_pc, pc_target
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: load beats increment beats hold; increment wraps silently.
module fetch_pc_reg #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1
);
  logic [ADDR_W-1:0] pc_reg;

  assign pc_plus1 = pc_reg + ADDR_W'(1);
  assign pc       = pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (load) begin
      pc_reg <= load_val;
    end else if (inc) begin
      pc_reg <= pc_plus1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: assembles one- and two-byte instructions
// from program memory and presents them registered to the control stage.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  fetch_state_t      state_reg, state_next;
  logic [7:0]        held_op_reg, held_op_next;
  logic [7:0]        opcode_reg, opcode_next;
  logic [7:0]        operand_reg, operand_next;
  logic [ADDR_W-1:0] ret_addr_reg, ret_addr_next;
  logic              valid_reg, valid_next;
  logic              pc_load, pc_inc;
  logic [ADDR_W-1:0] pc, pc_plus1;

  fetch_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_val(bus.pc_target),
    .pc      (pc),
    .pc_plus1(pc_plus1)
  );

  assign bus.imem_addr    = pc;
  assign bus.opcode_out   = opcode_reg;
  assign bus.operand_out  = operand_reg;
  assign bus.ret_addr_out = ret_addr_reg;
  assign bus.valid_out    = valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_OP;
      held_op_reg  <= OPC_NOP;
      opcode_reg   <= OPC_NOP;
      operand_reg  <= 8'h00;
      ret_addr_reg <= RESET_PC;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      held_op_reg  <= held_op_next;
      opcode_reg   <= opcode_next;
      operand_reg  <= operand_next;
      ret_addr_reg <= ret_addr_next;
      valid_reg    <= valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    held_op_next  = held_op_reg;
    opcode_next   = opcode_reg;
    operand_next  = operand_reg;
    ret_addr_next = ret_addr_reg;
    valid_next    = valid_reg;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;

    if (bus.l_pc) begin
      // Redirect discards any half-fetched instruction
      pc_load      = 1'b1;
      state_next   = S_FLUSH;
      held_op_next = OPC_NOP;
      opcode_next  = OPC_NOP;
      operand_next = 8'h00;
      valid_next   = 1'b0;
    end else if (!bus.stall) begin
      unique case (state_reg)
        S_OP: begin
          pc_inc = 1'b1;
          if (is_two_byte(bus.imem_data)) begin
            held_op_next = bus.imem_data;
            opcode_next  = OPC_NOP;
            operand_next = 8'h00;
            valid_next   = 1'b0;
            state_next   = S_OD;
          end else begin
            opcode_next   = bus.imem_data;
            operand_next  = 8'h00;
            ret_addr_next = pc_plus1;
            valid_next    = 1'b1;
          end
        end
        S_OD: begin
          pc_inc        = 1'b1;
          opcode_next   = held_op_reg;
          operand_next  = bus.imem_data;
          ret_addr_next = pc_plus1;
          valid_next    = 1'b1;
          state_next    = S_OP;
        end
        S_FLUSH: begin
          opcode_next  = OPC_NOP;
          operand_next = 8'h00;
          valid_next   = 1'b0;
          state_next   = S_OP;
        end
        default: begin
          state_next = S_OP;
          valid_next = 1'b0;
        end
      endcase
    end
  end
endmodule
